// File: rtl/mag_adc_sequencer_pkg.sv
// Shared axis codes, sequencer FSM encoding and axis-mask walking helpers.
package mag_adc_sequencer_pkg;

  typedef logic [1:0] axis_t;

  localparam axis_t AX_X = 2'd0;
  localparam axis_t AX_Y = 2'd1;
  localparam axis_t AX_Z = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECT,
    ST_SETTLE,
    ST_CONVERT,
    ST_EMIT
  } state_e;

  function automatic axis_t first_axis(input logic [2:0] mask);
    return mask[0] ? AX_X : (mask[1] ? AX_Y : AX_Z);
  endfunction

  function automatic axis_t last_axis(input logic [2:0] mask);
    return mask[2] ? AX_Z : (mask[1] ? AX_Y : AX_X);
  endfunction

  // Only meaningful when cur is not the last enabled axis of mask.
  function automatic axis_t next_axis(input logic [2:0] mask, input axis_t cur);
    if (cur == AX_X) return mask[1] ? AX_Y : AX_Z;
    return AX_Z;
  endfunction

endpackage

// File: rtl/mag_adc_sequencer_if.sv
// SAR/MUX handshake and result bus between the sequencer (master) and analog front-end / axis router (slave).
interface mag_adc_sequencer_if
  import mag_adc_sequencer_pkg::*;
#(
  parameter int ADC_BITS = 10
);
  axis_t               mux_ctrl;
  logic                sar_start;
  logic                sar_done;
  logic [ADC_BITS-1:0] sar_code;
  logic [ADC_BITS-1:0] adc_code;
  logic                adc_valid;
  axis_t               mux_sel;
  logic                frame_done;

  modport master (
    output mux_ctrl, sar_start, adc_code, adc_valid, mux_sel, frame_done,
    input  sar_done, sar_code
  );

  modport slave (
    input  mux_ctrl, sar_start, adc_code, adc_valid, mux_sel, frame_done,
    output sar_done, sar_code
  );
endinterface

// File: rtl/mag_seq_timer.sv
// Loadable saturating down-counter; zero flag reflects the registered count.
module mag_seq_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);
  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)                    cnt_d = load_val_i;
    else if (dec_i && cnt_q != '0) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign zero_o = (cnt_q == '0);
endmodule

// File: rtl/mag_adc_sequencer.sv
// Per-axis MUX select, settle wait and one SAR conversion; sar_done at t gives adc_valid at t+1.
// MAG_SEQ_TIMEOUT_EN adds a conversion watchdog with a sticky timeout_err.
module mag_adc_sequencer
  import mag_adc_sequencer_pkg::*;
#(
  parameter int ADC_BITS    = 10,
  parameter int SETTLE_W    = 8,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic [2:0]          axis_mask,
  input  logic [SETTLE_W-1:0] settle_cycles,
  output logic                busy,
  output logic                timeout_err,
  mag_adc_sequencer_if.master sar
);
  state_e              state_q, state_d;
  axis_t               ptr_q, ptr_d;
  logic [2:0]          mask_q, mask_d;
  logic [SETTLE_W-1:0] settle_q, settle_d;
  logic [ADC_BITS-1:0] code_q, code_d;
  logic                first_q, first_d;
  logic                skip_q, skip_d;
  logic                settle_load, settle_dec, settle_zero;
  logic                conv_enter, start_frame;
  logic                emit_vld;

  mag_seq_timer #(.W(SETTLE_W)) u_settle (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (settle_load),
    .load_val_i (settle_q - 1'b1),
    .dec_i      (settle_dec),
    .zero_o     (settle_zero)
  );

`ifdef MAG_SEQ_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC);
  logic err_q, err_d;
  logic wd_zero;

  // Loaded on CONVERT entry so the count reaches zero TIMEOUT_CYC-1 cycles after sar_start.
  mag_seq_timer #(.W(WD_W)) u_watchdog (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (conv_enter),
    .load_val_i (WD_W'(TIMEOUT_CYC - 1)),
    .dec_i      (state_q == ST_CONVERT),
    .zero_o     (wd_zero)
  );
  assign timeout_err = err_q;
`else
  assign timeout_err = 1'b0;
`endif

  assign first_d = conv_enter;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      ptr_q    <= AX_X;
      mask_q   <= '0;
      settle_q <= '0;
      code_q   <= '0;
      first_q  <= 1'b0;
      skip_q   <= 1'b0;
`ifdef MAG_SEQ_TIMEOUT_EN
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      mask_q   <= mask_d;
      settle_q <= settle_d;
      code_q   <= code_d;
      first_q  <= first_d;
      skip_q   <= skip_d;
`ifdef MAG_SEQ_TIMEOUT_EN
      err_q    <= err_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    mask_d      = mask_q;
    settle_d    = settle_q;
    code_d      = code_q;
    skip_d      = skip_q;
    settle_load = 1'b0;
    settle_dec  = 1'b0;
    conv_enter  = 1'b0;
    start_frame = 1'b0;
`ifdef MAG_SEQ_TIMEOUT_EN
    err_d       = err_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (enable && axis_mask != 3'b000) start_frame = 1'b1;
      end
      ST_SELECT: begin
        skip_d = 1'b0;
        if (settle_q == '0) begin
          conv_enter = 1'b1;
        end else begin
          settle_load = 1'b1;
          state_d     = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (settle_zero) conv_enter = 1'b1;
        else             settle_dec = 1'b1;
      end
      ST_CONVERT: begin
        // A done pulse coinciding with sar_start cannot belong to this conversion.
        if (!first_q && sar.sar_done) begin
          code_d  = sar.sar_code;
          state_d = ST_EMIT;
        end
`ifdef MAG_SEQ_TIMEOUT_EN
        else if (wd_zero) begin
          err_d   = 1'b1;
          skip_d  = 1'b1;
          state_d = ST_EMIT;
        end
`endif
      end
      ST_EMIT: begin
        if (!enable) begin
          state_d = ST_IDLE;
        end else if (ptr_q != last_axis(mask_q)) begin
          ptr_d   = next_axis(mask_q, ptr_q);
          state_d = ST_SELECT;
        end else if (axis_mask != 3'b000) begin
          start_frame = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (start_frame) begin
      mask_d   = axis_mask;
      settle_d = settle_cycles;
      ptr_d    = first_axis(axis_mask);
      state_d  = ST_SELECT;
    end
    if (conv_enter) state_d = ST_CONVERT;
  end

  always_comb begin
    emit_vld       = (state_q == ST_EMIT) && !skip_q;
    busy           = (state_q != ST_IDLE);
    sar.mux_ctrl   = (state_q != ST_IDLE) ? ptr_q : AX_X;
    sar.sar_start  = (state_q == ST_CONVERT) && first_q;
    sar.adc_valid  = emit_vld;
    sar.adc_code   = emit_vld ? code_q : '0;
    sar.mux_sel    = emit_vld ? ptr_q : AX_X;
    sar.frame_done = (state_q == ST_EMIT) && (ptr_q == last_axis(mask_q));
  end
endmodule
